// File: rtl/axis_pack_16to32.sv
// axis_pack_16to32: packs a 16-bit AXI-Stream into a 32-bit stream, with the optional packet counter enabled by AXIS_PACK_16TO32_CNT_EN
module axis_pack_16to32 (
  input  logic        clock,
  input  logic        rst,
  input  logic        origin_tvalid_i,
  output logic        origin_tready_o,
  input  logic [15:0] origin_tdata_i,
  input  logic        origin_tuser_i,
  input  logic        origin_tlast_i,
  output logic        pack_tvalid_o,
  input  logic        pack_tready_i,
  output logic [31:0] pack_tdata_o,
  output logic [3:0]  pack_tkeep_o,
  output logic        pack_tuser_o,
  output logic        pack_tlast_o,
  output logic [15:0] pkt_cnt
);
  typedef enum logic {LOW, HIGH} state_t;
  state_t      state_q;
  logic [15:0] hold_q;
  logic        hold_user_q;
  logic        tvalid_q, tuser_q, tlast_q;
  logic [31:0] tdata_q;
  logic [3:0]  tkeep_q;
  logic        accept, drain;
  assign origin_tready_o = !tvalid_q || pack_tready_i;
  assign accept          = origin_tvalid_i && origin_tready_o;
  assign drain           = tvalid_q && pack_tready_i;
  assign pack_tvalid_o   = tvalid_q;
  assign pack_tdata_o    = tdata_q;
  assign pack_tkeep_o    = tkeep_q;
  assign pack_tuser_o    = tuser_q;
  assign pack_tlast_o    = tlast_q;
  // Pairing FSM: hold the low half-word, emit a full word on the high half or a half word on an early tlast
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= LOW;
      hold_q      <= '0;
      hold_user_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      if (drain) tvalid_q <= 1'b0;
      if (accept) begin
        if (state_q == HIGH) begin
          tvalid_q    <= 1'b1;
          tdata_q     <= {origin_tdata_i, hold_q};
          tkeep_q     <= 4'b1111;
          tuser_q     <= hold_user_q | origin_tuser_i;
          tlast_q     <= origin_tlast_i;
          hold_q      <= '0;
          hold_user_q <= 1'b0;
          state_q     <= LOW;
        end else if (origin_tlast_i) begin
          tvalid_q <= 1'b1;
          tdata_q  <= {16'h0000, origin_tdata_i};
          tkeep_q  <= 4'b0011;
          tuser_q  <= origin_tuser_i;
          tlast_q  <= 1'b1;
        end else begin
          hold_q      <= origin_tdata_i;
          hold_user_q <= hold_user_q | origin_tuser_i;
          state_q     <= HIGH;
        end
      end
    end
  end
`ifdef AXIS_PACK_16TO32_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d   = (drain && tlast_q) ? cnt_q + 16'd1 : cnt_q;
  assign pkt_cnt = cnt_q;
  // Count packets as their final word leaves the block
  always_ff @(posedge clock or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign pkt_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_axis_pack_16to32.sv
// tb_axis_pack_16to32: directed and randomized checks of the 16-to-32 packer against a beat-queue model
module tb_axis_pack_16to32;
  logic        clock = 1'b0;
  logic        rst;
  logic        o_tvalid, o_tready, o_tuser, o_tlast;
  logic [15:0] o_tdata;
  logic        p_tvalid, p_tready, p_tuser, p_tlast;
  logic [31:0] p_tdata;
  logic [3:0]  p_tkeep;
  logic [15:0] pkt_cnt;
  always #5 clock = ~clock;
  axis_pack_16to32 dut (
    .clock(clock), .rst(rst),
    .origin_tvalid_i(o_tvalid), .origin_tready_o(o_tready), .origin_tdata_i(o_tdata),
    .origin_tuser_i(o_tuser), .origin_tlast_i(o_tlast),
    .pack_tvalid_o(p_tvalid), .pack_tready_i(p_tready), .pack_tdata_o(p_tdata),
    .pack_tkeep_o(p_tkeep), .pack_tuser_o(p_tuser), .pack_tlast_o(p_tlast),
    .pkt_cnt(pkt_cnt)
  );
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic u; logic l;} word_t;
  word_t       exp_q[$];
  logic [15:0] pend_d[$];
  logic        pend_u[$];
  int          tests = 0, fails = 0;
  int unsigned cnt_model = 0;
  bit          rand_rdy = 0, stall_prev = 0;
  word_t       prev_w;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  function automatic void model_beat(input logic [15:0] d, input logic u, input logic l);
    if (pend_d.size() == 0) begin
      if (l) exp_q.push_back('{d: {16'h0000, d}, k: 4'h3, u: u, l: 1'b1});
      else begin pend_d.push_back(d); pend_u.push_back(u); end
    end else begin
      exp_q.push_back('{d: {d, pend_d[0]}, k: 4'hF, u: pend_u[0] | u, l: l});
      pend_d.delete(); pend_u.delete();
    end
  endfunction
  function automatic logic [15:0] cnt_exp();
`ifdef AXIS_PACK_16TO32_CNT_EN
    return cnt_model[15:0];
`else
    return 16'h0000;
`endif
  endfunction
  task automatic cycle(output bit acc);
    word_t cur, w;
    if (rand_rdy) p_tready = ($urandom_range(0, 3) != 0);
    #1;
    cur = '{d: p_tdata, k: p_tkeep, u: p_tuser, l: p_tlast};
    if (stall_prev) chk("stable", {p_tvalid, cur}, {1'b1, prev_w});
    chk("tready_rule", o_tready, !p_tvalid || p_tready);
    acc = o_tvalid && o_tready;
    if (acc) model_beat(o_tdata, o_tuser, o_tlast);
    if (p_tvalid && p_tready) begin
      if (exp_q.size() == 0) chk("spurious_word", cur, '0);
      else begin
        w = exp_q.pop_front();
        chk("word", cur, w);
        if (w.l) cnt_model++;
      end
    end
    stall_prev = p_tvalid && !p_tready;
    prev_w = cur;
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic send(input logic [15:0] d, input logic u, input logic l);
    bit acc;
    int n = 0;
    o_tvalid = 1'b1; o_tdata = d; o_tuser = u; o_tlast = l;
    do begin cycle(acc); n++; end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 0, 1);
    o_tvalid = 1'b0;
  endtask
  task automatic drain();
    bit acc;
    int n = 0;
    o_tvalid = 1'b0;
    while ((exp_q.size() != 0 || p_tvalid) && n < 500) begin cycle(acc); n++; end
    chk("drain_done", {exp_q.size() == 0, p_tvalid}, {1'b1, 1'b0});
    chk("pkt_cnt", pkt_cnt, cnt_exp());
  endtask
  initial begin
    bit acc;
    int len;
    o_tvalid = 0; o_tdata = '0; o_tuser = 0; o_tlast = 0; p_tready = 1; rst = 1;
    #1;
    chk("reset_tready", o_tready, 1'b1);
    @(negedge clock); @(negedge clock);
    chk("reset_out", {p_tvalid, p_tdata, p_tkeep, p_tuser, p_tlast, pkt_cnt}, '0);
    chk("reset_tready2", o_tready, 1'b1);
    rst = 0;
    @(negedge clock);
    send(16'h1111, 0, 0); send(16'h2222, 0, 0); send(16'h3333, 0, 0); send(16'h4444, 0, 1);
    drain();
    send(16'hAAAA, 0, 0); send(16'hBBBB, 0, 0); send(16'hCCCC, 0, 1);
    drain();
    send(16'h5A5A, 1, 1);
    chk("single_latency", {p_tvalid, p_tdata, p_tkeep, p_tlast, p_tuser}, {1'b1, 32'h0000_5A5A, 4'h3, 1'b1, 1'b1});
    drain();
    p_tready = 0;
    send(16'h1234, 0, 0); send(16'h5678, 1, 0);
    o_tvalid = 1; o_tdata = 16'h9ABC; o_tuser = 0; o_tlast = 1;
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      chk("bp_blocked", {acc, o_tready}, 2'b00);
    end
    p_tready = 1;
    send(16'h9ABC, 0, 1);
    drain();
    send(16'h7777, 0, 0);
    rst = 1;
    #1;
    chk("midpkt_reset", {p_tvalid, p_tdata, o_tready}, {1'b0, 32'h0, 1'b1});
    pend_d.delete(); pend_u.delete(); stall_prev = 0;
`ifdef AXIS_PACK_16TO32_CNT_EN
    cnt_model = 0;
`endif
    @(negedge clock);
    rst = 0;
    send(16'h0001, 0, 0); send(16'h0002, 0, 1);
    chk("after_reset_word", {p_tvalid, p_tdata, p_tkeep, p_tlast}, {1'b1, 32'h0002_0001, 4'hF, 1'b1});
    drain();
    rand_rdy = 1;
    for (int p = 0; p < 300; p++) begin
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) cycle(acc);
        send(16'($urandom), 1'($urandom_range(0, 7) == 0), b == len - 1);
      end
    end
    rand_rdy = 0; p_tready = 1;
    drain();
    for (int i = 0; i < 65536; i++) send(16'(i), 0, 1);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axis_pack_16to32.md
AXIS_PACK_16TO32 -- requirements
Module: axis_pack_16to32

Interface
REQ-001 Parameter: none; input width fixed at 16 bits, output width 32 bits, user width 1 bit.
REQ-002 clock  input  1  single block clock; all state sampled on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 origin_inf  axi_stream_inf.slave  DSIZE=16, USIZE=1  input stream (tvalid, tready, tdata[15:0], tuser[0], tlast); interface aclk/aresetn unused, block runs on clock/rst.
REQ-005 pack_inf  axi_stream_inf.master  DSIZE=32, USIZE=1, KSIZE=4  packed output stream (tvalid, tready, tdata[31:0], tkeep[3:0], tuser[0], tlast).
REQ-006 pkt_cnt  output  16  count of completed output packets (see Configuration).

Function
REQ-007 State machine SHALL have two states: LOW (no half-word held) and HIGH (low half-word held in hold register).
REQ-008 Input beat accepted when origin tvalid && origin tready.
REQ-009 origin tready SHALL equal !pack tvalid || pack tready (output register free or draining this cycle); it SHALL not depend on origin tvalid.
REQ-010 LOW + accepted beat, tlast=0 -> store tdata into hold[15:0], OR tuser into hold_user, go HIGH; no output.
REQ-011 LOW + accepted beat, tlast=1 -> load output: tdata={16'h0000, beat}, tkeep=4'b0011, tlast=1, tuser=beat tuser; stay LOW.
REQ-012 HIGH + accepted beat (any tlast) -> load output: tdata={beat, hold}, tkeep=4'b1111, tlast=beat tlast, tuser=hold_user | beat tuser; go LOW.
REQ-013 Output is a registered stage: pack tvalid asserts the cycle after the completing input beat is accepted (latency 1 clock from completing beat).
REQ-014 pack tvalid, tdata, tkeep, tuser, tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-015 pack tvalid clears after a handshake unless a new output is loaded the same cycle; back-to-back loads SHALL sustain one output per two input beats with no bubbles when tready=1.
REQ-016 Simultaneous output handshake and new load: new word replaces old in same cycle, tvalid stays 1.
REQ-017 Packets never merged: a tlast beat always terminates the current output word.
REQ-018 Unused tdata bits SHALL be driven zero, never stale hold data.

Reset
REQ-019 rst=1 asynchronously forces state LOW, hold=0, hold_user=0, pack tvalid=0, tdata=0, tkeep=0, tuser=0, tlast=0, pkt_cnt=0.
REQ-020 Reset mid-packet SHALL discard held half-word; first beat after reset release is treated as a packet-low half.
REQ-021 origin tready SHALL be 1 during and immediately after reset (output register empty).

Configuration
REQ-022 Macro AXIS_PACK_16TO32_CNT_EN compiles in a packet counter.
REQ-023 Defined: pkt_cnt increments by 1 on each output handshake with tlast=1; wraps 16'hFFFF -> 16'h0000; reset to 0.
REQ-024 Not defined: pkt_cnt SHALL be tied to 16'h0000 and no counter logic synthesized; all other behaviour identical.

Verification
REQ-025 Beats 16'h1111,16'h2222,16'h3333,16'h4444(last), tready=1 -> outputs 32'h2222_1111 keep F last 0, then 32'h4444_3333 keep F last 1; pkt_cnt=1 (CNT_EN).
REQ-026 Odd packet 16'hAAAA,16'hBBBB,16'hCCCC(last) -> 32'hBBBB_AAAA keep F, then 32'h0000_CCCC keep 3 last 1.
REQ-027 Single-beat packet 16'h5A5A(last) tuser=1 -> 32'h0000_5A5A keep 3 last 1 tuser 1, one cycle after acceptance.
REQ-028 Hold pack tready=0 for 5 cycles with output pending -> origin tready=0, output stable; release -> transfer resumes, no beat lost or duplicated.
REQ-029 Assert rst after 16'h7777 accepted (state HIGH), release, send 16'h0001,16'h0002(last) -> single output 32'h0002_0001; 16'h7777 never appears.
REQ-030 With CNT_EN, 65536 single-beat packets -> pkt_cnt returns to 16'h0000; without CNT_EN pkt_cnt stays 0 throughout.
